// File: rtl/cordic_pkg.sv
// Shared constants for the CORDIC rotation datapath: arctangent table,
// iteration count, inverse gain and the output saturation helper.
package cordic_pkg;

    localparam int ITER  = 32;
    localparam int LUT_W = 32;

    localparam logic [31:0] CORDIC_K_INV = 32'h26DD_3B6A;

    // Binary-angle arctangents, full circle = 2^32.
    localparam logic [31:0] ATAN_LUT [0:31] = '{
        32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
        32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
        32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
        32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
        32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
        32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
        32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
        32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000
    };

    function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v,
                                                     input int unsigned w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] r;
        hi = (64'sd1 <<< (w - 32'd1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 32'd1));
        if (v > hi) begin
            r = hi;
        end else if (v < lo) begin
            r = lo;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/cordic_result_fifo.sv
// Two-entry result buffer; head data comes straight from storage so it holds
// steady under back-pressure.
module cordic_result_fifo
    import cordic_pkg::*;
#(
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [1:0]    count
);

    logic [DW-1:0] mem_q [0:1];
    logic [DW-1:0] mem_d [0:1];
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    count_q, count_d;
    logic          pop_s;
    logic          wr_ptr_s;

    // Next-state for storage, read pointer and occupancy.
    always_comb begin
        pop_s    = (count_q != 2'd0) && out_ready;
        wr_ptr_s = rd_ptr_q ^ count_q[0];
        for (int i = 0; i < 2; i++) begin
            mem_d[i] = (push && (wr_ptr_s == 1'(i))) ? push_data : mem_q[i];
        end
        rd_ptr_d = pop_s ? ~rd_ptr_q : rd_ptr_q;
        case ({push, pop_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= {DW{1'b0}};
            mem_q[1] <= {DW{1'b0}};
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign out_valid = (count_q != 2'd0);
    assign out_data  = mem_q[rd_ptr_q];
    assign count     = count_q;

    cordic_result_fifo_chk u_chk (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .count (count_q)
    );

endmodule

// File: rtl/cordic_result_fifo_chk.sv
// Protocol checker for the result buffer: a push must always find a free slot.
module cordic_result_fifo_chk (
    input logic       clk,
    input logic       rst,
    input logic       push,
    input logic [1:0] count
);

    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) push |-> (count != 2'd2));

endmodule

// File: rtl/cordic_rotate_dp.sv
// Iterative CORDIC rotation datapath paced by cordic_fsm: quadrant pre-rotation
// on accept, one micro-rotation per running cycle, saturated capture on done.
module cordic_rotate_dp
    import cordic_pkg::*;
#(
    parameter int W  = 32,
    parameter int IW = W + 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] in_angle,
    input  logic signed [W-1:0] in_mag,
    output logic                start,
    input  logic [4:0]          iter_cnt,
    input  logic                done,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] out_cos,
    output logic signed [W-1:0] out_sin
);

    logic signed [IW-1:0] x_q, x_d, y_q, y_d;
    logic signed [IW-1:0] x_sh_s, y_sh_s, mag_ext_s;
    logic signed [W-1:0]  z_q, z_d, atan_s;
    logic                 busy_q, busy_d;
    logic                 start_q, start_d;
    logic                 running_q, running_d;
    logic                 accept_s, quad_s, push_s;
    logic [1:0]           count_s;
    logic [2*W-1:0]       push_data_s, head_s;

    assign in_ready = !busy_q && (count_s < 2'd2);

    // Accept/pre-rotation, micro-rotation step and control next-state.
    always_comb begin
        accept_s  = in_valid && in_ready;
        quad_s    = in_angle[W-1] ^ in_angle[W-2];
        mag_ext_s = IW'(in_mag);
        x_sh_s    = x_q >>> iter_cnt;
        y_sh_s    = y_q >>> iter_cnt;
        atan_s    = W'(ATAN_LUT[iter_cnt] >> (LUT_W - W));
        push_s    = done && busy_q;
        push_data_s = {W'(sat_clamp(64'(x_q), W)), W'(sat_clamp(64'(y_q), W))};

        if (accept_s) begin
            x_d = quad_s ? -mag_ext_s : mag_ext_s;
            y_d = {IW{1'b0}};
            z_d = quad_s ? (in_angle ^ {1'b1, {(W-1){1'b0}}}) : in_angle;
        end else if (running_q) begin
            if (!z_q[W-1]) begin
                x_d = x_q - y_sh_s;
                y_d = y_q + x_sh_s;
                z_d = z_q - atan_s;
            end else begin
                x_d = x_q + y_sh_s;
                y_d = y_q - x_sh_s;
                z_d = z_q + atan_s;
            end
        end else begin
            x_d = x_q;
            y_d = y_q;
            z_d = z_q;
        end

        start_d = accept_s;

        if (start_q) begin
            running_d = 1'b1;
        end else if (running_q && (iter_cnt == 5'(ITER - 1))) begin
            running_d = 1'b0;
        end else begin
            running_d = running_q;
        end

        // busy reserves a buffer slot from accept until the result is pushed.
        if (accept_s) begin
            busy_d = 1'b1;
        end else if (push_s) begin
            busy_d = 1'b0;
        end else begin
            busy_d = busy_q;
        end
    end

    // Datapath and control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q       <= {IW{1'b0}};
            y_q       <= {IW{1'b0}};
            z_q       <= {W{1'b0}};
            busy_q    <= 1'b0;
            start_q   <= 1'b0;
            running_q <= 1'b0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            z_q       <= z_d;
            busy_q    <= busy_d;
            start_q   <= start_d;
            running_q <= running_d;
        end
    end

    assign start = start_q;

    cordic_result_fifo #(.DW(2 * W)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (push_data_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head_s),
        .count     (count_s)
    );

    assign out_cos = head_s[2*W-1:W];
    assign out_sin = head_s[W-1:0];

endmodule

// File: tb/tb_cordic_rotate_dp.sv
// Directed bench for cordic_rotate_dp with a behavioural cordic_fsm model and
// a queue of expected results compared as each output is popped.
module tb_cordic_rotate_dp;

    localparam int  W   = 32;
    localparam logic signed [W-1:0] MAG = 32'sd652032874;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] in_angle;
    logic signed [W-1:0] in_mag;
    logic                start;
    logic [4:0]          iter_cnt = 5'd0;
    logic                fsm_done = 1'b0;
    logic                inj_done;
    logic                done;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out_cos;
    logic signed [W-1:0] out_sin;

    typedef struct {
        longint c;
        longint s;
    } exp_t;

    exp_t   sb[$];
    int     n_checks = 0;
    int     n_fail   = 0;
    int     cyc      = 0;
    int     ph       = 0;
    int     start_dbl = 0;
    logic   start_prev = 1'b0;
    longint last_acc = 0;
    longint ov_cyc   = 0;

    logic [31:0] angs [5] = '{32'h4000_0000, 32'h8000_0000, 32'hA000_0000, 32'h2000_0000, 32'hE000_0000};
    longint      ecos [5] = '{0, -1073741824, -759250125, 759250125, 759250125};
    longint      esin [5] = '{1073741824, 0, -759250125, 759250125, -759250125};

    always #5 clk = ~clk;

    assign done = fsm_done | inj_done;

    cordic_rotate_dp #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_angle  (in_angle),
        .in_mag    (in_mag),
        .start     (start),
        .iter_cnt  (iter_cnt),
        .done      (done),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_cos   (out_cos),
        .out_sin   (out_sin)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Counts cycles where start is high for a second consecutive cycle.
    always @(posedge clk) begin
        start_prev <= start;
        if (start && start_prev) start_dbl <= start_dbl + 1;
    end

    // cordic_fsm model: iter_cnt 0..31 on the 32 cycles after start, one DONE cycle, then done.
    always @(posedge clk) begin
        if (rst) begin
            ph       <= 0;
            iter_cnt <= 5'd0;
            fsm_done <= 1'b0;
        end else if (ph == 0) begin
            if (start) begin
                ph       <= 1;
                iter_cnt <= 5'd0;
            end
        end else if (ph < 32) begin
            iter_cnt <= 5'(ph);
            ph       <= ph + 1;
        end else if (ph == 32) begin
            iter_cnt <= 5'd0;
            ph       <= 33;
        end else if (ph == 33) begin
            fsm_done <= 1'b1;
            ph       <= 34;
        end else begin
            fsm_done <= 1'b0;
            ph       <= 0;
        end
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input longint obs, input longint exp);
        longint diff = obs - exp;
        logic   ok   = (diff <= 64'sd16) && (diff >= -64'sd16);
        n_checks++;
        assert (ok === 1'b1) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d+-16", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] angle, input longint ec, input longint es);
        logic ok = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_angle = angle;
        in_mag   = MAG;
        for (int i = 0; i < 200; i++) begin
            if (in_ready) begin
                ok       = 1'b1;
                last_acc = cyc;
                sb.push_back('{ec, es});
                break;
            end
            @(negedge clk);
        end
        check("accept", longint'(ok), 64'sd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        logic seen = 1'b0;
        exp_t e;
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (out_valid) begin
                seen   = 1'b1;
                ov_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_valid"}, longint'(seen), 64'sd1);
        if (seen) begin
            check({tag, "_sb_nonempty"}, longint'(sb.size() != 0), 64'sd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check_near({tag, "_cos"}, longint'(out_cos), e.c);
                check_near({tag, "_sin"}, longint'(out_sin), e.s);
            end
        end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int rdy_hi;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_angle  = 32'sd0;
        in_mag    = 32'sd0;
        out_ready = 1'b0;
        inj_done  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_start",     longint'(start),     64'sd0);
        check("rst_out_valid", longint'(out_valid), 64'sd0);
        check("rst_out_cos",   longint'(out_cos),   64'sd0);
        check("rst_out_sin",   longint'(out_sin),   64'sd0);
        check("rst_in_ready",  longint'(in_ready),  64'sd1);

        // Angle 0: start pulse timing, busy, 36-cycle latency.
        send(32'h0000_0000, 64'sd1073741824, 64'sd0);
        check("start_a1", longint'(start), 64'sd1);
        @(negedge clk);
        check("start_a2", longint'(start), 64'sd0);
        check("busy_a2",  longint'(in_ready), 64'sd0);
        drain("ang0");
        check("latency", ov_cyc - last_acc, 64'sd36);

        for (int k = 0; k < 5; k++) begin
            send(angs[k], ecos[k], esin[k]);
            drain("sweep");
        end

        // Back-pressure: two results fill the buffer, the third waits for a pop.
        send(32'h0000_0000, 64'sd1073741824, 64'sd0);
        send(32'h4000_0000, 64'sd0, 64'sd1073741824);
        repeat (36) @(negedge clk);
        check("full_in_ready", longint'(in_ready), 64'sd0);
        check_near("head_hold", longint'(out_cos), 64'sd1073741824);
        rdy_hi = 0;
        fork
            send(32'h8000_0000, -64'sd1073741824, 64'sd0);
            begin
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    if (in_ready) rdy_hi++;
                end
                check("full_ready_cycles", longint'(rdy_hi), 64'sd0);
                drain("bp_a");
            end
        join
        drain("bp_b");
        drain("bp_c");

        // Reset at a+20 with one result already buffered.
        send(32'h2000_0000, 64'sd759250125, 64'sd759250125);
        send(32'hA000_0000, -64'sd759250125, -64'sd759250125);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_start",     longint'(start),     64'sd0);
        check("mid_rst_out_valid", longint'(out_valid), 64'sd0);
        check("mid_rst_in_ready",  longint'(in_ready),  64'sd1);
        sb.delete();
        send(32'hE000_0000, 64'sd759250125, -64'sd759250125);
        drain("post_rst");

        // Stray done while idle must not push.
        @(negedge clk);
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        check("stray_done_valid", longint'(out_valid), 64'sd0);
        check("stray_done_ready", longint'(in_ready),  64'sd1);
        repeat (2) @(negedge clk);
        check("stray_done_valid2", longint'(out_valid), 64'sd0);

        check("start_single_cycle", longint'(start_dbl), 64'sd0);
        check("sb_empty", longint'(sb.size()), 64'sd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
